// File: rtl/mandel_pixel_scheduler.sv
// Frame scheduler: walks the visible raster handing pixel jobs round-robin to idle engines, and funnels results round-robin onto the framebuffer write port.
// Latency: job grant is combinational; result accept -> fb_we is 1 cycle; frame_done follows the final accept by 2 cycles.
// Backpressure: jobs go only to engines raising job_ready; results wait in their engine until granted via res_ready.
module mandel_pixel_scheduler #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int N_ENG     = 4,
  parameter int ADDR_W    = 19
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  input  logic [N_ENG-1:0]        job_ready,
  output logic [N_ENG-1:0]        job_valid,
  output logic [9:0]              job_x,
  output logic [9:0]              job_y,
  output logic [ADDR_W-1:0]       job_addr,
  input  logic [N_ENG-1:0]        res_valid,
  output logic [N_ENG-1:0]        res_ready,
  input  logic [N_ENG*ADDR_W-1:0] res_addr,
  input  logic [N_ENG*8-1:0]      res_data,
  output logic                    fb_we,
  output logic [ADDR_W-1:0]       fb_waddr,
  output logic [7:0]              fb_wdata
);
  localparam int PTR_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
  localparam int OUT_W = $clog2(N_ENG + 1);
  localparam logic [PTR_W-1:0] LAST_ENG = PTR_W'(N_ENG - 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(N_ENG);
  localparam logic [9:0]       X_LAST   = 10'(H_VISIBLE - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_VISIBLE - 1);

  typedef enum logic [2:0] {IDLE, DISPATCH, DRAIN, FLUSH, DONE} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] disp_ptr, res_ptr;
  logic [OUT_W-1:0] outstanding, outstanding_nxt;
  logic [PTR_W:0]   disp_pick, res_pick;   // {found, engine index}
  logic             dispatch, accept, last_pixel;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]       acc_data;

  // First requester at or after ptr, walking the engines cyclically.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_ENG-1:0] req,
                                             input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0]   r;
    logic [PTR_W-1:0] e;
    int               idx;
    r = '0;
    for (int k = N_ENG - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_ENG;
      e   = PTR_W'(idx);
      if (req[e]) r = {1'b1, e};
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] g);
    return (g == LAST_ENG) ? '0 : g + PTR_W'(1);
  endfunction

  // Job and result arbitration; the two sides are independent of each other.
  always_comb begin
    disp_pick  = rr_pick(job_ready, disp_ptr);
    res_pick   = rr_pick(res_valid, res_ptr);
    dispatch   = (state == DISPATCH) && disp_pick[PTR_W] && (outstanding != OUT_MAX);
    accept     = ((state == DISPATCH) || (state == DRAIN)) && res_pick[PTR_W] &&
                 (outstanding != '0);
    job_valid  = '0;
    res_ready  = '0;
    if (dispatch) job_valid[disp_pick[PTR_W-1:0]] = 1'b1;
    if (accept)   res_ready[res_pick[PTR_W-1:0]]  = 1'b1;
    acc_addr   = res_addr[res_pick[PTR_W-1:0]*ADDR_W +: ADDR_W];
    acc_data   = res_data[res_pick[PTR_W-1:0]*8 +: 8];
    last_pixel = (job_x == X_LAST) && (job_y == Y_LAST);
    outstanding_nxt = outstanding;
    if (dispatch && !accept)      outstanding_nxt = outstanding + OUT_W'(1);
    else if (accept && !dispatch) outstanding_nxt = outstanding - OUT_W'(1);
  end

  // Frame sequencing: next state plus busy / frame_done decode.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = DISPATCH;
      end
      DISPATCH: if (dispatch && last_pixel) state_nxt = DRAIN;
      DRAIN:    if (outstanding_nxt == '0) state_nxt = FLUSH;
      FLUSH:    state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Raster walk: cleared while idle, advanced once per dispatched job.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      job_x    <= '0;
      job_y    <= '0;
      job_addr <= '0;
    end else if (state == IDLE) begin
      job_x    <= '0;
      job_y    <= '0;
      job_addr <= '0;
    end else if (dispatch) begin
      job_addr <= job_addr + ADDR_W'(1);
      if (job_x == X_LAST) begin
        job_x <= '0;
        job_y <= job_y + 10'd1;
      end else begin
        job_x <= job_x + 10'd1;
      end
    end
  end

  // Round-robin pointers and in-flight job count.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      disp_ptr    <= '0;
      res_ptr     <= '0;
      outstanding <= '0;
    end else begin
      if (dispatch) disp_ptr <= ptr_after(disp_pick[PTR_W-1:0]);
      if (accept)   res_ptr  <= ptr_after(res_pick[PTR_W-1:0]);
      outstanding <= (state == IDLE) ? '0 : outstanding_nxt;
    end
  end

  // Framebuffer write port: the accepted result lands one cycle later.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
    end else begin
      fb_we <= accept;
      if (accept) begin
        fb_waddr <= acc_addr;
        fb_wdata <= acc_data;
      end
    end
  end
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Bench for mandel_pixel_scheduler on an 8x4 raster with two engines.
// Engines are modelled with random latencies; expectations come from raster order and round-robin rules.
// Inputs change on the falling edge and outputs are sampled there too.
module tb_mandel_pixel_scheduler;
  localparam int H = 8;
  localparam int V = 4;
  localparam int N = 2;
  localparam int AW = 19;
  localparam int NPIX = H * V;
  localparam int BUDGET = 3000;

  logic            CLOCK_50 = 1'b0;
  logic            RESET, start;
  logic            busy, frame_done;
  logic [N-1:0]    job_ready, job_valid, res_valid, res_ready;
  logic [9:0]      job_x, job_y;
  logic [AW-1:0]   job_addr, fb_waddr;
  logic [N*AW-1:0] res_addr;
  logic [N*8-1:0]  res_data;
  logic            fb_we;
  logic [7:0]      fb_wdata;

  mandel_pixel_scheduler #(.H_VISIBLE(H), .V_VISIBLE(V), .N_ENG(N), .ADDR_W(AW)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .start(start), .busy(busy), .frame_done(frame_done),
    .job_ready(job_ready), .job_valid(job_valid), .job_x(job_x), .job_y(job_y),
    .job_addr(job_addr), .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
    .res_data(res_data), .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0, checks = 0, cyc = 0;
  // Engine model
  bit         eng_busy[N], eng_has[N], eng_dis[N];
  int         eng_cnt[N], eng_idx[N], lat_lo[N], lat_hi[N];
  logic [7:0] eng_dat[N];
  int         drop_pct;
  bit         jt[N], rt[N];
  // Frame model
  bit         pend_wr, frame_on, start_acc, final_seen;
  int         pend_addr;
  logic [7:0] pend_dat;
  int         exp_dptr, exp_rptr, jobs_sent, res_acc, last_acc_cyc;
  int         writes, done_pulses, max_out, both_valid_cycles;
  int         wr_count[NPIX];
  int         eng_jobs[N];
  logic       start_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester found walking upward (cyclically) from ptr.
  function automatic logic [N-1:0] rr_expect(input logic [N-1:0] req, input int ptr);
    logic [N-1:0] g;
    int e;
    g = '0;
    for (int k = 0; k < N; k++) begin
      e = (ptr + k) % N;
      if (req[e] && g == '0) g[e] = 1'b1;
    end
    return g;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      eng_busy[i] = 0; eng_has[i] = 0; jt[i] = 0; rt[i] = 0;
      eng_cnt[i] = 0; eng_idx[i] = 0; eng_dat[i] = '0;
    end
    pend_wr = 0; frame_on = 0; start_acc = 0; final_seen = 0;
    exp_dptr = 0; exp_rptr = 0; jobs_sent = 0; res_acc = 0; last_acc_cyc = 0;
  endtask

  // One clock cycle: check what the last edge produced, move the engines, drive, check grants.
  task automatic step();
    logic [N-1:0] exp_jv, exp_rv;
    @(negedge CLOCK_50);
    cyc++;
    chk("fb_we", fb_we, pend_wr);
    if (pend_wr) begin
      chk("fb_waddr", fb_waddr, pend_addr);
      chk("fb_wdata", fb_wdata, pend_dat);
      writes++;
      if (pend_addr >= 0 && pend_addr < NPIX) wr_count[pend_addr]++;
    end
    pend_wr = 0;
    for (int i = 0; i < N; i++) begin
      if (jt[i]) begin
        eng_busy[i] = 1; eng_has[i] = 0;
        eng_cnt[i] = int'($urandom_range(lat_hi[i], lat_lo[i]));
      end else if (rt[i]) begin
        eng_busy[i] = 0; eng_has[i] = 0;
      end
      if (eng_busy[i] && !eng_has[i]) begin
        eng_cnt[i]--;
        if (eng_cnt[i] <= 0) eng_has[i] = 1;
      end
      jt[i] = 0; rt[i] = 0;
    end
    if (start_acc) begin frame_on = 1; start_acc = 0; end
    if (final_seen && cyc == last_acc_cyc + 3) frame_on = 0;
    chk("busy", busy, frame_on);
    chk("frame_done", frame_done, final_seen && cyc == last_acc_cyc + 2);
    if (frame_done) done_pulses++;
    for (int i = 0; i < N; i++) begin
      job_ready[i] = !eng_busy[i] && !eng_dis[i] && ($urandom_range(99) >= drop_pct);
      res_valid[i] = eng_has[i];
      res_addr[i*AW +: AW] = AW'(eng_idx[i]);
      res_data[i*8 +: 8] = eng_dat[i];
    end
    start = start_req;
    #1;
    exp_jv = (frame_on && jobs_sent < NPIX) ? rr_expect(job_ready, exp_dptr) : '0;
    chk("job_valid", job_valid, exp_jv);
    if (exp_jv != '0) begin
      chk("job_x", job_x, jobs_sent % H);
      chk("job_y", job_y, jobs_sent / H);
      chk("job_addr", job_addr, jobs_sent);
    end
    for (int i = 0; i < N; i++) begin
      if (exp_jv[i]) exp_dptr = (i + 1) % N;
      jt[i] = job_valid[i] & job_ready[i];
      if (jt[i]) begin
        eng_idx[i] = jobs_sent;
        eng_dat[i] = 8'($urandom);
        jobs_sent++;
        eng_jobs[i]++;
      end
    end
    exp_rv = frame_on ? rr_expect(res_valid, exp_rptr) : '0;
    chk("res_ready", res_ready, exp_rv);
    if (res_valid == '1) both_valid_cycles++;
    for (int i = 0; i < N; i++) begin
      if (exp_rv[i]) exp_rptr = (i + 1) % N;
      rt[i] = res_valid[i] & res_ready[i];
      if (rt[i]) begin
        pend_wr = 1; pend_addr = eng_idx[i]; pend_dat = eng_dat[i];
        res_acc++;
        if (res_acc == NPIX) begin final_seen = 1; last_acc_cyc = cyc; end
      end
    end
    if (jobs_sent - res_acc > max_out) max_out = jobs_sent - res_acc;
    if (start_req && !frame_on) begin
      start_acc = 1; final_seen = 0; jobs_sent = 0; res_acc = 0;
    end
  endtask

  // Pulse start and run until the frame has fully retired (or abort after some writes).
  task automatic run_frame(input int mid_start_at, input int abort_after);
    int n;
    bit missing;
    writes = 0; done_pulses = 0; max_out = 0; both_valid_cycles = 0;
    for (int a = 0; a < NPIX; a++) wr_count[a] = 0;
    for (int i = 0; i < N; i++) eng_jobs[i] = 0;
    start_req = 1; step(); start_req = 0;
    n = 0;
    while (!(final_seen && cyc >= last_acc_cyc + 4) && n < BUDGET) begin
      start_req = (n == mid_start_at);
      step();
      n++;
      if (abort_after > 0 && writes >= abort_after) begin
        start_req = 0;
        return;
      end
    end
    start_req = 0;
    chk("frame_within_budget", n < BUDGET, 1'b1);
    chk("write_count", writes, NPIX);
    chk("frame_done_pulses", done_pulses, 1);
    missing = 0;
    for (int a = 0; a < NPIX; a++) if (wr_count[a] != 1) missing = 1;
    chk("each_addr_once", missing, 1'b0);
  endtask

  task automatic set_lat(input int lo0, input int hi0, input int lo1, input int hi1);
    lat_lo[0] = lo0; lat_hi[0] = hi0; lat_lo[1] = lo1; lat_hi[1] = hi1;
  endtask

  initial begin
    RESET = 1; start = 0; start_req = 0;
    job_ready = '0; res_valid = '0; res_addr = '0; res_data = '0;
    drop_pct = 0; eng_dis[0] = 0; eng_dis[1] = 0;
    set_lat(3, 3, 3, 3);
    clear_model();
    @(negedge CLOCK_50); @(negedge CLOCK_50);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_job_valid", job_valid, '0);
    chk("rst_res_ready", res_ready, '0);
    chk("rst_job_x", job_x, '0);
    chk("rst_job_y", job_y, '0);
    chk("rst_job_addr", job_addr, '0);
    chk("rst_fb_we", fb_we, 1'b0);
    chk("rst_fb_waddr", fb_waddr, '0);
    chk("rst_fb_wdata", fb_wdata, '0);
    RESET = 0;

    // Both engines always ready, fixed latency: jobs alternate 0,1,0,1...
    run_frame(-1, 0);
    chk("alt_eng0_jobs", eng_jobs[0], NPIX / 2);
    chk("alt_eng1_jobs", eng_jobs[1], NPIX / 2);

    // Engine 1 never ready: everything goes to engine 0, one job in flight at most.
    eng_dis[1] = 1;
    set_lat(1, 4, 1, 4);
    run_frame(-1, 0);
    chk("solo_eng0_jobs", eng_jobs[0], NPIX);
    chk("solo_eng1_jobs", eng_jobs[1], 0);
    chk("solo_max_outstanding", max_out <= 1, 1'b1);
    eng_dis[1] = 0;

    // Skewed latencies line results up on the same cycle; a stray start mid-frame is ignored.
    set_lat(4, 4, 3, 3);
    run_frame(20, 0);
    chk("both_results_seen", both_valid_cycles > 0, 1'b1);

    // Random readiness and latency, out-of-order results.
    set_lat(1, 6, 1, 6);
    drop_pct = 30;
    run_frame(15, 0);

    // Abort after 10 writes with an asynchronous reset, then a clean frame.
    run_frame(-1, 10);
    #2 RESET = 1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_frame_done", frame_done, 1'b0);
    chk("abort_job_valid", job_valid, '0);
    chk("abort_res_ready", res_ready, '0);
    chk("abort_job_addr", job_addr, '0);
    chk("abort_fb_we", fb_we, 1'b0);
    chk("abort_fb_waddr", fb_waddr, '0);
    chk("abort_fb_wdata", fb_wdata, '0);
    clear_model();
    step(); step(); step();
    RESET = 0;
    step(); step();
    run_frame(-1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
